// File: rtl/pin_pattern_driver.sv
// Board test jig stimulus: walking-one pin test with looped-back compare and RGB status PWM.
// Optional PIN_TEST_WALK_ZERO_EN adds a second walking-zero pass after a clean walking-one pass.
module pin_pattern_driver #(
  parameter int NUM_PINS      = 29,
  parameter int SETTLE_CYCLES = 16,
  parameter int PWM_BITS      = 8,
  parameter int LED_DUTY      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic [NUM_PINS-1:0]         pin_out,
  output logic [NUM_PINS-1:0]         pin_oe,
  input  logic [NUM_PINS-1:0]         pin_in,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [$clog2(NUM_PINS)-1:0] fail_index,
  output logic [NUM_PINS-1:0]         fail_data,
  output logic                        led_r_pwm,
  output logic                        led_g_pwm,
  output logic                        led_b_pwm
);
  localparam int IW = $clog2(NUM_PINS);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, FINISH} state_t;

  state_t              state;
  logic [IW-1:0]       idx;
  logic [SW-1:0]       settle_cnt;
  logic [NUM_PINS-1:0] sync1, sync2;
  logic                has_result;
  logic [PWM_BITS:0]   pwm_cnt;
`ifdef PIN_TEST_WALK_ZERO_EN
  logic                phase;
`endif

  logic [NUM_PINS-1:0] walk, walk_next, expected, next_pat;
  logic                last, match, final_pass, pwm_on, blink;

  always_comb begin
    walk      = NUM_PINS'(1) << idx;
    walk_next = walk << 1;
    last      = (idx == IW'(NUM_PINS - 1));
`ifdef PIN_TEST_WALK_ZERO_EN
    expected   = phase ? ~walk : walk;
    next_pat   = phase ? ~walk_next : walk_next;
    final_pass = phase;
`else
    expected   = walk;
    next_pat   = walk_next;
    final_pass = 1'b1;
`endif
    match = (sync2 == expected);
  end

  // Response pins are asynchronous to clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pin_in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      settle_cnt <= '0;
      pin_out    <= '0;
      pin_oe     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_index <= '0;
      fail_data  <= '0;
      has_result <= 1'b0;
`ifdef PIN_TEST_WALK_ZERO_EN
      phase      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state   <= DRIVE;
          idx     <= '0;
          busy    <= 1'b1;
          pass    <= 1'b0;
          pin_oe  <= '1;
          pin_out <= NUM_PINS'(1);
`ifdef PIN_TEST_WALK_ZERO_EN
          phase   <= 1'b0;
`endif
        end
        DRIVE: begin
          state      <= SETTLE;
          settle_cnt <= SW'(SETTLE_CYCLES - 1);
        end
        SETTLE: begin
          if (settle_cnt == '0) state <= SAMPLE;
          else settle_cnt <= settle_cnt - SW'(1);
        end
        SAMPLE: begin
          if (!match || (last && final_pass)) begin
            state      <= FINISH;
            done       <= 1'b1;
            busy       <= 1'b0;
            pin_oe     <= '0;
            pin_out    <= '0;
            pass       <= match;
            has_result <= 1'b1;
            if (!match) begin
              fail_index <= idx;
              fail_data  <= sync2;
            end
          end else begin
`ifdef PIN_TEST_WALK_ZERO_EN
            // Walking-one clean: restart the index for the walking-zero pass.
            if (last) begin
              phase   <= 1'b1;
              idx     <= '0;
              pin_out <= ~NUM_PINS'(1);
            end else
`endif
            begin
              idx     <= idx + IW'(1);
              pin_out <= next_pat;
            end
            state <= DRIVE;
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Extra counter bit above the PWM period acts as the busy blink gate.
  assign pwm_on = (pwm_cnt[PWM_BITS-1:0] < PWM_BITS'(LED_DUTY));
  assign blink  = ~pwm_cnt[PWM_BITS];

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt   <= '0;
      led_r_pwm <= 1'b0;
      led_g_pwm <= 1'b0;
      led_b_pwm <= 1'b0;
    end else begin
      pwm_cnt   <= pwm_cnt + (PWM_BITS+1)'(1);
      led_b_pwm <= busy & pwm_on & blink;
      led_g_pwm <= ~busy & has_result & pass & pwm_on;
      led_r_pwm <= ~busy & has_result & ~pass & pwm_on;
    end
  end
endmodule
